// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: merges ninputs val/rdy request streams onto one output
// stream with rotating priority and a 1-entry registered output buffer.
// Optionally overwrites the top $clog2(ninputs) message bits with the source
// index so a downstream router can steer replies back.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   istream_val    [ninputs-1:0]        request valid, bit i = source i
//   istream_msg    [ninputs*nbits-1:0]  request messages, source i at [i*nbits +: nbits]
//   istream_rdy    [ninputs-1:0]        accept, one-hot or zero (combinational)
//   ostream_val    merged output valid (registered)
//   ostream_msg    [nbits-1:0] merged output message (registered)
//   ostream_rdy    downstream ready
module round_robin_arbiter #(
    parameter int unsigned nbits   = 32,
    parameter int unsigned ninputs = 4,
    parameter bit          tag_en  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ninputs-1:0]         istream_val,
    input  logic [ninputs*nbits-1:0]   istream_msg,
    output logic [ninputs-1:0]         istream_rdy,
    output logic                       ostream_val,
    output logic [nbits-1:0]           ostream_msg,
    input  logic                       ostream_rdy
);

    localparam int unsigned ptr_w = $clog2(ninputs);

    logic [ptr_w-1:0] ptr_q, ptr_d;
    logic             out_val_q, out_val_d;
    logic [nbits-1:0] out_msg_q, out_msg_d;

    logic             hi_found, lo_found;
    logic [ptr_w-1:0] hi_idx, lo_idx;
    logic             gnt_valid;
    logic [ptr_w-1:0] gnt_idx;
    logic [nbits-1:0] sel_msg;
    logic             can_accept;
    logic             xfer;

    // Rotating-priority search: the lowest valid index at or above ptr wins,
    // otherwise the lowest valid index below ptr (wrap modulo ninputs).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(ninputs) - 1; i >= 0; i--) begin
            if (istream_val[i]) begin
                if (ptr_w'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ptr_w'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ptr_w'(i);
                end
            end
        end
        gnt_valid = hi_found || lo_found;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Winning message, tagged with its source index when enabled.
    always_comb begin
        sel_msg = '0;
        for (int i = 0; i < int'(ninputs); i++) begin
            if (ptr_w'(i) == gnt_idx) begin
                sel_msg = istream_msg[i*nbits +: nbits];
            end
        end
        if (tag_en) begin
            sel_msg[nbits-1 -: ptr_w] = gnt_idx;
        end
    end

    // Buffer may refill in the same cycle it drains.
    assign can_accept = !out_val_q || ostream_rdy;
    assign xfer       = !reset && can_accept && gnt_valid;

    always_comb begin
        istream_rdy = '0;
        for (int i = 0; i < int'(ninputs); i++) begin
            istream_rdy[i] = xfer && (ptr_w'(i) == gnt_idx);
        end
    end

    // Next state for pointer and output buffer.
    always_comb begin
        ptr_d     = ptr_q;
        out_val_d = out_val_q;
        out_msg_d = out_msg_q;
        if (xfer) begin
            out_val_d = 1'b1;
            out_msg_d = sel_msg;
            ptr_d     = (gnt_idx == ptr_w'(ninputs - 1)) ? '0 : ptr_w'(gnt_idx + ptr_w'(1));
        end else if (ostream_rdy) begin
            out_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            out_val_q <= 1'b0;
            out_msg_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            out_val_q <= out_val_d;
            out_msg_q <= out_msg_d;
        end
    end

    assign ostream_val = out_val_q;
    assign ostream_msg = out_msg_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter: a 4-input tagged instance driven
// from a vector table, and a 3-input untagged instance driven by hand.
module tb_round_robin_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-input, tagged instance
    logic         rst4;
    logic [3:0]   val4;
    logic [127:0] msg4;
    logic [3:0]   rdy4;
    logic         oval4;
    logic [31:0]  omsg4;
    logic         ordy4;

    // 3-input, untagged instance
    logic         rst3;
    logic [2:0]   val3;
    logic [95:0]  msg3;
    logic [2:0]   rdy3;
    logic         oval3;
    logic [31:0]  omsg3;
    logic         ordy3;

    round_robin_arbiter #(.nbits(32), .ninputs(4), .tag_en(1'b1)) dut4 (
        .clk(clk), .reset(rst4),
        .istream_val(val4), .istream_msg(msg4), .istream_rdy(rdy4),
        .ostream_val(oval4), .ostream_msg(omsg4), .ostream_rdy(ordy4)
    );

    round_robin_arbiter #(.nbits(32), .ninputs(3), .tag_en(1'b0)) dut3 (
        .clk(clk), .reset(rst3),
        .istream_val(val3), .istream_msg(msg3), .istream_rdy(rdy3),
        .ostream_val(oval3), .ostream_msg(omsg3), .ostream_rdy(ordy3)
    );

    typedef struct packed {
        logic         rst;
        logic [3:0]   val;
        logic [127:0] msgs;
        logic         ordy;
        logic [3:0]   erdy;
        logic         eoval;
        logic [31:0]  emsg;
    } vec_t;

    localparam int NV = 26;
    vec_t tv [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] val, input logic [127:0] msgs,
                                input logic ordy, input logic [3:0] erdy, input logic eoval,
                                input logic [31:0] emsg);
        vec_t v;
        v.rst = rst; v.val = val; v.msgs = msgs; v.ordy = ordy;
        v.erdy = erdy; v.eoval = eoval; v.emsg = emsg;
        return v;
    endfunction

    // Message sets, source i in bits [i*32 +: 32]
    localparam logic [127:0] MA = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    localparam logic [127:0] MB = {32'h0000_5678, 32'h0000_1234, 32'h0, 32'h0};
    localparam logic [127:0] MC = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h0};

    // 3-input reference: untagged messages and expected grant order
    logic [31:0] m3 [3];
    int          g3 [4];

    initial begin
        // Each row: inputs applied after negedge; expectations are the
        // combinational rdy and the registered outputs before the next edge.
        tv[0]  = mk(1, 4'b1111, MA, 1, 4'b0000, 0, 32'h0);
        tv[1]  = mk(0, 4'b1111, MA, 1, 4'b0001, 0, 32'h0);
        tv[2]  = mk(0, 4'b1111, MA, 1, 4'b0010, 1, 32'h0000_00A0);
        tv[3]  = mk(0, 4'b1111, MA, 1, 4'b0100, 1, 32'h4000_00A1);
        tv[4]  = mk(0, 4'b1111, MA, 1, 4'b1000, 1, 32'h8000_00A2);
        tv[5]  = mk(0, 4'b1111, MA, 1, 4'b0001, 1, 32'hC000_00A3);
        tv[6]  = mk(0, 4'b0000, MA, 1, 4'b0000, 1, 32'h0000_00A0);
        tv[7]  = mk(0, 4'b0000, MA, 1, 4'b0000, 0, 32'h0000_00A0);
        // backpressure: source 2, then source 3 queued behind a stall
        tv[8]  = mk(0, 4'b0100, MB, 1, 4'b0100, 0, 32'h0000_00A0);
        tv[9]  = mk(0, 4'b1000, MB, 0, 4'b0000, 1, 32'h8000_1234);
        tv[10] = mk(0, 4'b1000, MB, 0, 4'b0000, 1, 32'h8000_1234);
        tv[11] = mk(0, 4'b1000, MB, 0, 4'b0000, 1, 32'h8000_1234);
        tv[12] = mk(0, 4'b1000, MB, 1, 4'b1000, 1, 32'h8000_1234);
        tv[13] = mk(0, 4'b0000, MB, 1, 4'b0000, 1, 32'hC000_5678);
        // skip and wrap: move ptr to 3, then sources 1 and 3 only
        tv[14] = mk(0, 4'b0100, MC, 1, 4'b0100, 0, 32'hC000_5678);
        tv[15] = mk(0, 4'b1010, MC, 1, 4'b1000, 1, 32'h8000_0022);
        tv[16] = mk(0, 4'b1010, MC, 1, 4'b0010, 1, 32'hC000_0033);
        tv[17] = mk(0, 4'b1010, MC, 1, 4'b1000, 1, 32'h4000_0011);
        tv[18] = mk(0, 4'b1000, MC, 1, 4'b1000, 1, 32'hC000_0033);
        tv[19] = mk(0, 4'b0000, MC, 1, 4'b0000, 1, 32'hC000_0033);
        // lone source keeps winning while ptr moves past it
        tv[20] = mk(0, 4'b0010, MC, 1, 4'b0010, 0, 32'hC000_0033);
        tv[21] = mk(0, 4'b0010, MC, 1, 4'b0010, 1, 32'h4000_0011);
        // reset while stalled discards the buffered message
        tv[22] = mk(0, 4'b0000, MC, 0, 4'b0000, 1, 32'h4000_0011);
        tv[23] = mk(1, 4'b0000, MC, 0, 4'b0000, 1, 32'h4000_0011);
        tv[24] = mk(0, 4'b1111, MC, 1, 4'b0001, 0, 32'h0);
        tv[25] = mk(0, 4'b0000, MC, 1, 4'b0000, 1, 32'h0);

        m3[0] = 32'h0000_0010;
        m3[1] = 32'h0000_0011;
        m3[2] = 32'hFFFF_0001;
        g3[0] = 0; g3[1] = 1; g3[2] = 2; g3[3] = 0;

        rst4 = 1'b1; val4 = 4'b1111; msg4 = MA; ordy4 = 1'b1;
        rst3 = 1'b1; val3 = 3'b000;  msg3 = '0; ordy3 = 1'b1;
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst4 = tv[i].rst; val4 = tv[i].val; msg4 = tv[i].msgs; ordy4 = tv[i].ordy;
            #1;
            chk($sformatf("v%0d rdy", i),  32'(rdy4),  32'(tv[i].erdy));
            chk($sformatf("v%0d oval", i), 32'(oval4), 32'(tv[i].eoval));
            chk($sformatf("v%0d omsg", i), omsg4,      tv[i].emsg);
        end

        // 3-input untagged instance
        @(negedge clk);
        val4 = 4'b0000;
        rst3 = 1'b0;
        msg3 = {m3[2], m3[1], m3[0]};
        val3 = 3'b100;
        #1;
        chk("n3 first rdy", 32'(rdy3), 32'h4);
        chk("n3 reset oval", 32'(oval3), 32'h0);
        @(negedge clk);
        val3 = 3'b111;
        #1;
        chk("n3 untagged msg", omsg3, 32'hFFFF_0001);
        chk("n3 oval", 32'(oval3), 32'h1);
        // ptr wrapped 2 -> 0: all valid yields grants 0,1,2,0
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("n3 grant%0d rdy", k), 32'(rdy3), 32'(1 << g3[k]));
            @(negedge clk);
            #1;
            chk($sformatf("n3 grant%0d msg", k), omsg3, m3[g3[k]]);
        end
        val3 = 3'b000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
